booth_multiplier_param: RTL and testbench



---
 rtl/booth_multiplier_param.sv | 106 ++++++++++
 tb/tb_booth_multiplier_param.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier_param.sv
// booth_multiplier_param: iterative radix-4 Booth multiplier with result hold, flush and optional early termination.
module booth_multiplier_param #(
    parameter int WIDTH      = 64,
    parameter bit EARLY_TERM = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             mul_valid,
    output logic             mul_ready,
    input  logic             flush,
    input  logic             mulw,
    input  logic [1:0]       mul_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             mul_doing,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);
    localparam int H  = WIDTH / 2;
    localparam int AW = 2 * WIDTH + 2;
    localparam int YW = WIDTH + 3;
    localparam int CW = $clog2(WIDTH / 2 + 2);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d, x_q, x_d, x2, pp, x_init;
    logic [YW-1:0]   y_q, y_d, y_init;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mulw_q, mulw_d;
    logic            xe, ye, redundant, last;
    logic [WIDTH-1:0] x_n, y_n;
    logic [2:0]      sel;
    logic            unused;
    assign xe     = mul_signed[1] & (mulw ? multiplicand[H-1] : multiplicand[WIDTH-1]);
    assign ye     = mul_signed[0] & (mulw ? multiplier[H-1] : multiplier[WIDTH-1]);
    assign x_n    = mulw ? {{H{xe}}, multiplicand[H-1:0]} : multiplicand;
    assign y_n    = mulw ? {{H{ye}}, multiplier[H-1:0]} : multiplier;
    assign x_init = {{(AW-WIDTH){xe}}, x_n};
    assign y_init = {ye, ye, y_n, 1'b0};
    assign sel    = y_q[2:0];
    assign x2     = x_q << 1;
    assign pp     = (sel == 3'b001 || sel == 3'b010) ? x_q :
                    (sel == 3'b011)                  ? x2 :
                    (sel == 3'b100)                  ? ~x2 + AW'(1) :
                    (sel == 3'b101 || sel == 3'b110) ? ~x_q + AW'(1) : '0;
    // Remaining multiplier bits all equal means every further Booth digit is zero
    assign redundant = EARLY_TERM && (y_q == '0 || y_q == '1);
    assign last      = cnt_q == CW'(mulw_q ? WIDTH / 4 : WIDTH / 2);
    assign mul_ready = (state_q == IDLE) & ~flush;
    assign mul_doing = state_q == BUSY;
    assign out_valid = state_q == DONE;
    assign result_lo = out_valid ? (mulw_q ? {{H{acc_q[H-1]}}, acc_q[H-1:0]} : acc_q[WIDTH-1:0]) : '0;
    assign result_hi = (out_valid && !mulw_q) ? acc_q[2*WIDTH-1:WIDTH] : '0;
    assign unused    = ^acc_q[AW-1:2*WIDTH];
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        mulw_d  = mulw_q;
        case (state_q)
            IDLE: if (mul_valid && mul_ready) begin
                state_d = BUSY;
                acc_d   = '0;
                x_d     = x_init;
                y_d     = y_init;
                cnt_d   = '0;
                mulw_d  = mulw;
            end
            BUSY: if (redundant) begin
                state_d = DONE;
            end else begin
                acc_d   = acc_q + pp;
                x_d     = x_q << 2;
                y_d     = {y_q[YW-1], y_q[YW-1], y_q[YW-1:2]};
                cnt_d   = cnt_q + CW'(1);
                state_d = last ? DONE : BUSY;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush && state_q != IDLE) begin
            state_d = IDLE;
            acc_d   = '0;
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            mulw_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            mulw_q  <= mulw_d;
        end
    end
endmodule

// File: tb/tb_booth_multiplier_param.sv
// tb_booth_multiplier_param: directed vectors against a full-iteration and an early-terminating instance.
module tb_booth_multiplier_param;
    localparam int W = 64;
    logic clock = 1'b0, reset_n = 1'b0, mul_valid = 1'b0, flush = 1'b0, mulw = 1'b0, out_ready = 1'b1;
    logic [1:0] mul_signed = 2'b00;
    logic [W-1:0] multiplicand = '0, multiplier = '0;
    logic ready0, doing0, ov0, ready1, doing1, ov1;
    logic [W-1:0] hi0, lo0, hi1, lo1;
    int checks = 0, failures = 0;

    booth_multiplier_param #(.WIDTH(W), .EARLY_TERM(1'b0)) dut0 (
        .clock(clock), .reset_n(reset_n), .mul_valid(mul_valid), .mul_ready(ready0), .flush(flush),
        .mulw(mulw), .mul_signed(mul_signed), .multiplicand(multiplicand), .multiplier(multiplier),
        .mul_doing(doing0), .out_valid(ov0), .out_ready(out_ready), .result_hi(hi0), .result_lo(lo0));
    booth_multiplier_param #(.WIDTH(W), .EARLY_TERM(1'b1)) dut1 (
        .clock(clock), .reset_n(reset_n), .mul_valid(mul_valid), .mul_ready(ready1), .flush(flush),
        .mulw(mulw), .mul_signed(mul_signed), .multiplicand(multiplicand), .multiplier(multiplier),
        .mul_doing(doing1), .out_valid(ov1), .out_ready(out_ready), .result_hi(hi1), .result_lo(lo1));

    always #5 clock = ~clock;

    typedef struct {
        logic         mw;
        logic [1:0]   sg;
        logic [W-1:0] x, y, hi, lo;
        int           l1;
    } vec_t;
    vec_t v[14];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic mw, input logic [1:0] sg, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clock);
        mulw = mw; mul_signed = sg; multiplicand = x; multiplier = y; mul_valid = 1'b1;
        @(posedge clock);
        #1 mul_valid = 1'b0;
        multiplicand = ~x; multiplier = ~y; mul_signed = ~sg; mulw = ~mw;
    endtask

    task automatic run_op(input string tag, input logic mw, input logic [1:0] sg, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] ehi, input logic [W-1:0] elo, input int el1);
        int f0 = 0, f1 = 0, dc = 0, oc = 0, s;
        logic [W-1:0] rh0 = 'x, rl0 = 'x, rh1 = 'x, rl1 = 'x;
        @(negedge clock);
        chk({tag, "_ready"}, {63'd0, ready0 & ready1}, 64'd1);
        start_op(mw, sg, x, y);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            dc += int'(doing0);
            oc += int'(ov0);
            if (ov0 && f0 == 0) begin f0 = i; rh0 = hi0; rl0 = lo0; end
            if (ov1 && f1 == 0) begin f1 = i; rh1 = hi1; rl1 = lo1; end
        end
        s = mw ? W / 4 + 1 : W / 2 + 1;
        chk({tag, "_lat0"}, 64'(f0), 64'(s + 1));
        chk({tag, "_doing0"}, 64'(dc), 64'(s));
        chk({tag, "_ovcnt0"}, 64'(oc), 64'd1);
        chk({tag, "_hi0"}, rh0, ehi);
        chk({tag, "_lo0"}, rl0, elo);
        chk({tag, "_hi1"}, rh1, ehi);
        chk({tag, "_lo1"}, rl1, elo);
        if (el1 > 0) chk({tag, "_lat1"}, 64'(f1), 64'(el1));
    endtask

    initial begin
        int k, oc;
        v[0]  = '{1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 0};
        v[1]  = '{1'b0, 2'b11, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, 0};
        v[2]  = '{1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0};
        v[3]  = '{1'b1, 2'b11, 64'h7FFF_FFFF, 64'd2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 0};
        v[4]  = '{1'b0, 2'b00, 64'd5, 64'd0, 64'h0, 64'h0, 2};
        v[5]  = '{1'b0, 2'b00, 64'd5, 64'd1, 64'h0, 64'd5, 3};
        v[6]  = '{1'b0, 2'b11, 64'd6, 64'd7, 64'h0, 64'd42, 0};
        v[7]  = '{1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0};
        v[8]  = '{1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1, 0};
        v[9]  = '{1'b0, 2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h0, 0};
        v[10] = '{1'b1, 2'b00, 64'hDEAD_BEEF_FFFF_FFFF, 64'h1234_5678_FFFF_FFFF, 64'h0, 64'h1, 0};
        v[11] = '{1'b1, 2'b10, 64'hFFFF_FFFE, 64'd3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFA, 0};
        v[12] = '{1'b0, 2'b00, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1, 64'h0, 0};
        v[13] = '{1'b1, 2'b11, 64'h8000_0000, 64'h8000_0000, 64'h0, 64'h0, 0};
        #12;
        chk("rst_ready", {63'd0, ready0}, 64'd1);
        chk("rst_doing", {63'd0, doing0}, 64'd0);
        chk("rst_ov", {63'd0, ov0}, 64'd0);
        chk("rst_hi", hi0, 64'd0);
        chk("rst_lo", lo0, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 14; i++)
            run_op($sformatf("v%0d", i), v[i].mw, v[i].sg, v[i].x, v[i].y, v[i].hi, v[i].lo, v[i].l1);
        // Back-pressure: result must hold while the consumer stalls
        out_ready = 1'b0;
        start_op(1'b0, 2'b00, 64'd3, 64'd4);
        k = 0;
        while (!ov0 && k < 60) begin @(negedge clock); k++; end
        chk("bp_wait", {63'd0, ov0}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("bp_ov_%0d", i), {63'd0, ov0}, 64'd1);
            chk($sformatf("bp_hi_%0d", i), hi0, 64'd0);
            chk($sformatf("bp_lo_%0d", i), lo0, 64'd12);
            chk($sformatf("bp_ready_%0d", i), {63'd0, ready0}, 64'd0);
        end
        chk("bp_lo1", lo1, 64'd12);
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("bp_release_ov", {63'd0, ov0}, 64'd0);
        chk("bp_release_ready", {63'd0, ready0 & ready1}, 64'd1);
        // Flush together with out_ready in DONE drops the result
        out_ready = 1'b0;
        start_op(1'b0, 2'b11, 64'd6, 64'd7);
        k = 0;
        while (!ov0 && k < 60) begin @(negedge clock); k++; end
        chk("fd_wait", {63'd0, ov0}, 64'd1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        chk("fd_ov", {63'd0, ov0 | ov1}, 64'd0);
        chk("fd_ready", {63'd0, ready0}, 64'd1);
        chk("fd_lo", lo0, 64'd0);
        // Flush in IDLE blocks acceptance
        @(negedge clock);
        flush = 1'b1; mul_valid = 1'b1; multiplicand = 64'd6; multiplier = 64'd7; mul_signed = 2'b11; mulw = 1'b0;
        #1 chk("fi_ready", {63'd0, ready0 | ready1}, 64'd0);
        @(posedge clock);
        #1 flush = 1'b0; mul_valid = 1'b0;
        @(negedge clock);
        chk("fi_doing", {63'd0, doing0 | doing1}, 64'd0);
        // Flush on the 10th BUSY cycle
        start_op(1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 1; i <= 10; i++) @(negedge clock);
        chk("fb_doing_before", {63'd0, doing0}, 64'd1);
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        chk("fb_doing_after", {63'd0, doing0}, 64'd0);
        chk("fb_ready_after", {63'd0, ready0}, 64'd1);
        oc = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clock); oc += int'(ov0); end
        chk("fb_no_ov", 64'(oc), 64'd0);
        run_op("fb_next", 1'b0, 2'b11, 64'd6, 64'd7, 64'd0, 64'd42, 0);
        // Asynchronous reset mid-BUSY
        start_op(1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 1; i <= 5; i++) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("ar_ready", {63'd0, ready0}, 64'd1);
        chk("ar_doing", {63'd0, doing0}, 64'd0);
        chk("ar_ov", {63'd0, ov0}, 64'd0);
        chk("ar_hi", hi0, 64'd0);
        chk("ar_lo", lo0, 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        oc = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clock); oc += int'(ov0); end
        chk("ar_no_ov", 64'(oc), 64'd0);
        run_op("ar_next", 1'b0, 2'b11, 64'd6, 64'd7, 64'd0, 64'd42, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
